// File: rtl/alu_accumulator.sv
// Accumulator/flags execute stage: single-cycle arithmetic, logic and load ops,
// plus an optional iterative shift-add multiply that stalls the controller via busy.
module alu_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int INST_WIDTH = 8,
    parameter int MUL_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  exec,
    input  logic [INST_WIDTH-1:0] IR,
    input  logic [DATA_WIDTH-1:0] IBR,
    input  logic [DATA_WIDTH-1:0] MBR,
    output logic [DATA_WIDTH-1:0] AR,
    output logic [3:0]            Flags,
    output logic                  busy
);
    // Flag bit positions and the two load opcodes of the 00 class.
    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_NEG   = 2;
    localparam int FLAG_OV    = 3;
    localparam logic [7:0] LOAD_X = 8'h01;
    localparam logic [7:0] LOAD_I = 8'h02;
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t                    state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0]     ar_r, ar_nxt_s;
    logic [3:0]                flags_r, flags_nxt_s;
    logic                      busy_r, busy_nxt_s;
    logic [DATA_WIDTH-1:0]     mcand_r, mcand_nxt_s;
    logic [DATA_WIDTH-1:0]     mplier_r, mplier_nxt_s;
    logic [2*DATA_WIDTH-1:0]   prod_r, prod_nxt_s, partial_s;
    logic [CNT_W-1:0]          cnt_r, cnt_nxt_s;
    logic [DATA_WIDTH-1:0]     operand_s, logic_res_s;
    logic [DATA_WIDTH:0]       add_s, sub_s;
    logic                      src_ok_s, cin_s;

    function automatic logic add_ovf(input logic a, input logic b, input logic r);
        return (a == b) && (r != a);
    endfunction

    function automatic logic sub_ovf(input logic a, input logic b, input logic r);
        return (a != b) && (r != a);
    endfunction

    // Operand selection and datapath results for the single-cycle ops.
    always_comb begin
        src_ok_s    = (IR[5:2] == 4'b0000) || (IR[5:2] == 4'b0001);
        operand_s   = (IR[5:2] == 4'b0001) ? IBR : MBR;
        cin_s       = IR[0] ? flags_r[FLAG_CARRY] : 1'b0;
        add_s       = {1'b0, ar_r} + {1'b0, operand_s} + {{DATA_WIDTH{1'b0}}, cin_s};
        sub_s       = {1'b0, ar_r} - {1'b0, operand_s} - {{DATA_WIDTH{1'b0}}, cin_s};
        logic_res_s = ~ar_r;
        case (IR[1:0])
            2'b00:   logic_res_s = ar_r & operand_s;
            2'b01:   logic_res_s = ar_r | operand_s;
            2'b10:   logic_res_s = ar_r ^ operand_s;
            default: logic_res_s = ~ar_r;
        endcase
        partial_s = mplier_r[cnt_r] ? ({{DATA_WIDTH{1'b0}}, mcand_r} << cnt_r)
                                    : {(2*DATA_WIDTH){1'b0}};
    end

    // Next-state, accumulator and flag update; exec is ignored outside IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        ar_nxt_s     = ar_r;
        flags_nxt_s  = flags_r;
        busy_nxt_s   = busy_r;
        mcand_nxt_s  = mcand_r;
        mplier_nxt_s = mplier_r;
        prod_nxt_s   = prod_r;
        cnt_nxt_s    = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (exec) begin
                    case (IR[7:6])
                        2'b01: begin
                            if (src_ok_s) begin
                                if (IR[1]) begin
                                    ar_nxt_s              = sub_s[DATA_WIDTH-1:0];
                                    flags_nxt_s[FLAG_CARRY] = sub_s[DATA_WIDTH];
                                    flags_nxt_s[FLAG_OV]  = sub_ovf(ar_r[DATA_WIDTH-1], operand_s[DATA_WIDTH-1], sub_s[DATA_WIDTH-1]);
                                end else begin
                                    ar_nxt_s              = add_s[DATA_WIDTH-1:0];
                                    flags_nxt_s[FLAG_CARRY] = add_s[DATA_WIDTH];
                                    flags_nxt_s[FLAG_OV]  = add_ovf(ar_r[DATA_WIDTH-1], operand_s[DATA_WIDTH-1], add_s[DATA_WIDTH-1]);
                                end
                                flags_nxt_s[FLAG_ZERO] = (ar_nxt_s == {DATA_WIDTH{1'b0}});
                                flags_nxt_s[FLAG_NEG]  = ar_nxt_s[DATA_WIDTH-1];
                            end else begin
                                ar_nxt_s = ar_r;
                            end
                        end
                        2'b10: begin
                            if (src_ok_s) begin
                                ar_nxt_s               = logic_res_s;
                                flags_nxt_s[FLAG_ZERO] = (logic_res_s == {DATA_WIDTH{1'b0}});
                                flags_nxt_s[FLAG_NEG]  = logic_res_s[DATA_WIDTH-1];
                                flags_nxt_s[FLAG_OV]   = 1'b0;
                            end else begin
                                ar_nxt_s = ar_r;
                            end
                        end
                        2'b11: begin
                            if ((MUL_ENABLE != 0) && src_ok_s && (IR[1:0] == 2'b00)) begin
                                mcand_nxt_s  = ar_r;
                                mplier_nxt_s = operand_s;
                                prod_nxt_s   = {(2*DATA_WIDTH){1'b0}};
                                cnt_nxt_s    = {CNT_W{1'b0}};
                                busy_nxt_s   = 1'b1;
                                state_nxt_s  = ST_MUL;
                            end else begin
                                state_nxt_s = ST_IDLE;
                            end
                        end
                        default: begin
                            if ((IR[7:0] == LOAD_X) || (IR[7:0] == LOAD_I)) begin
                                ar_nxt_s               = (IR[7:0] == LOAD_I) ? IBR : MBR;
                                flags_nxt_s[FLAG_ZERO] = (ar_nxt_s == {DATA_WIDTH{1'b0}});
                                flags_nxt_s[FLAG_NEG]  = ar_nxt_s[DATA_WIDTH-1];
                            end else begin
                                ar_nxt_s = ar_r;
                            end
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                prod_nxt_s = prod_r + partial_s;
                cnt_nxt_s  = cnt_r + CNT_W'(1);
                if (cnt_r == CNT_LAST) begin
                    ar_nxt_s                = prod_nxt_s[DATA_WIDTH-1:0];
                    flags_nxt_s[FLAG_CARRY] = (prod_nxt_s[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{1'b0}});
                    flags_nxt_s[FLAG_OV]    = flags_nxt_s[FLAG_CARRY];
                    flags_nxt_s[FLAG_ZERO]  = (prod_nxt_s[DATA_WIDTH-1:0] == {DATA_WIDTH{1'b0}});
                    flags_nxt_s[FLAG_NEG]   = prod_nxt_s[DATA_WIDTH-1];
                    busy_nxt_s              = 1'b0;
                    state_nxt_s             = ST_IDLE;
                end else begin
                    state_nxt_s = ST_MUL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register; reset also aborts a multiply in flight.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_r  <= ST_IDLE;
            ar_r     <= {DATA_WIDTH{1'b0}};
            flags_r  <= 4'b0000;
            busy_r   <= 1'b0;
            mcand_r  <= {DATA_WIDTH{1'b0}};
            mplier_r <= {DATA_WIDTH{1'b0}};
            prod_r   <= {(2*DATA_WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            ar_r     <= ar_nxt_s;
            flags_r  <= flags_nxt_s;
            busy_r   <= busy_nxt_s;
            mcand_r  <= mcand_nxt_s;
            mplier_r <= mplier_nxt_s;
            prod_r   <= prod_nxt_s;
            cnt_r    <= cnt_nxt_s;
        end
    end

    assign AR    = ar_r;
    assign Flags = flags_r;
    assign busy  = busy_r;
endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator: vector table for single-cycle ops,
// hand sequences for multiply timing, exec-while-busy and reset during multiply.
module tb_alu_accumulator;
    logic       clk = 1'b0;
    logic       arst_n;
    logic       exec;
    logic [7:0] IR, IBR, MBR, AR;
    logic [3:0] Flags;
    logic       busy;
    int         n_tests = 0;
    int         n_fail  = 0;

    // Flags expected as {V, N, C, Z}.
    typedef struct {
        logic       e;
        logic [7:0] ir, ibr, mbr, ar;
        logic [3:0] fl;
    } vec_t;

    alu_accumulator #(.DATA_WIDTH(8), .INST_WIDTH(8), .MUL_ENABLE(1)) dut (
        .clk(clk), .arst_n(arst_n), .exec(exec), .IR(IR), .IBR(IBR), .MBR(MBR),
        .AR(AR), .Flags(Flags), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] ear, input logic [3:0] efl, input logic ebusy);
        n_tests++;
        if (AR !== ear || Flags !== efl || busy !== ebusy) begin
            n_fail++;
            $display("FAIL %s: AR=%h Flags=%b busy=%b, expected AR=%h Flags=%b busy=%b",
                     name, AR, Flags, busy, ear, efl, ebusy);
        end
    endtask

    // Drive at negedge, let one posedge pass, return at the following negedge.
    task automatic step(input logic e, input logic [7:0] ir, input logic [7:0] ibr, input logic [7:0] mbr);
        exec = e; IR = ir; IBR = ibr; MBR = mbr;
        @(posedge clk);
        @(negedge clk);
        exec = 1'b0;
    endtask

    vec_t vecs[19];

    initial begin
        vecs[0]  = '{1'b1, 8'h02, 8'h7F, 8'h00, 8'h7F, 4'h0}; // LOAD_I 7F
        vecs[1]  = '{1'b1, 8'h44, 8'h01, 8'h00, 8'h80, 4'hC}; // ADD imm 01
        vecs[2]  = '{1'b1, 8'h02, 8'h05, 8'h00, 8'h05, 4'h8}; // LOAD_I 05
        vecs[3]  = '{1'b1, 8'h42, 8'h00, 8'h06, 8'hFF, 4'h6}; // SUB MBR 06
        vecs[4]  = '{1'b1, 8'h45, 8'h00, 8'h00, 8'h00, 4'h3}; // ADC imm 00
        vecs[5]  = '{1'b1, 8'h02, 8'hAA, 8'h00, 8'hAA, 4'h6}; // LOAD_I AA
        vecs[6]  = '{1'b1, 8'h82, 8'h00, 8'hFF, 8'h55, 4'h2}; // XOR MBR FF
        vecs[7]  = '{1'b1, 8'h83, 8'h12, 8'h34, 8'hAA, 4'h6}; // NOT
        vecs[8]  = '{1'b1, 8'h84, 8'h0F, 8'h00, 8'h0A, 4'h2}; // AND imm 0F
        vecs[9]  = '{1'b1, 8'h81, 8'h00, 8'hF0, 8'hFA, 4'h6}; // OR MBR F0
        vecs[10] = '{1'b1, 8'h47, 8'h0A, 8'h00, 8'hEF, 4'h4}; // SBB imm 0A, C=1
        vecs[11] = '{1'b0, 8'h44, 8'h11, 8'h11, 8'hEF, 4'h4}; // no exec
        vecs[12] = '{1'b1, 8'h48, 8'h11, 8'h11, 8'hEF, 4'h4}; // undefined source
        vecs[13] = '{1'b1, 8'h01, 8'h33, 8'h00, 8'h00, 4'h1}; // LOAD_X 00
        vecs[14] = '{1'b1, 8'h46, 8'h01, 8'h00, 8'hFF, 4'h6}; // SUB imm 01
        vecs[15] = '{1'b1, 8'h43, 8'h00, 8'h7F, 8'h7F, 4'h8}; // SBB MBR 7F, C=1
        vecs[16] = '{1'b1, 8'h40, 8'h00, 8'h81, 8'h00, 4'h3}; // ADD MBR 81
        vecs[17] = '{1'b1, 8'h03, 8'h44, 8'h44, 8'h00, 4'h3}; // store/undefined
        vecs[18] = '{1'b1, 8'h02, 8'h10, 8'h00, 8'h10, 4'h2}; // LOAD_I 10

        arst_n = 1'b0; exec = 1'b0; IR = 8'h00; IBR = 8'h00; MBR = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        check("reset", 8'h00, 4'h0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].e, vecs[i].ir, vecs[i].ibr, vecs[i].mbr);
            check($sformatf("vec%0d", i), vecs[i].ar, vecs[i].fl, 1'b0);
        end

        // 0x10 * 0x20 = 0x0200, with an ADD issued mid-multiply that must be ignored.
        step(1'b1, 8'hC4, 8'h20, 8'h00);
        for (int c = 1; c < 8; c++) begin
            check($sformatf("mul1_busy%0d", c), 8'h10, 4'h2, 1'b1);
            if (c == 3) step(1'b1, 8'h44, 8'h55, 8'h00);
            else        step(1'b0, 8'h00, 8'h00, 8'h00);
        end
        check("mul1_busy8", 8'h10, 4'h2, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00);
        check("mul1_result", 8'h00, 4'hB, 1'b0);

        // 0x0D * 0x0B = 0x008F from the memory operand.
        step(1'b1, 8'h02, 8'h0D, 8'h00);
        check("load_0d", 8'h0D, 4'hA, 1'b0);
        step(1'b1, 8'hC0, 8'h00, 8'h0B);
        repeat (7) step(1'b0, 8'h00, 8'h00, 8'h00);
        check("mul2_last_busy", 8'h0D, 4'hA, 1'b1);
        step(1'b0, 8'h00, 8'h00, 8'h00);
        check("mul2_result", 8'h8F, 4'h4, 1'b0);

        // Reset on the third busy cycle aborts the multiply.
        step(1'b1, 8'hC4, 8'h03, 8'h00);
        step(1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00, 8'h00);
        check("mul3_busy3", 8'h8F, 4'h4, 1'b1);
        arst_n = 1'b0;
        step(1'b0, 8'h00, 8'h00, 8'h00);
        check("mul_abort", 8'h00, 4'h0, 1'b0);
        arst_n = 1'b1;
        step(1'b1, 8'h44, 8'h03, 8'h00);
        check("add_after_abort", 8'h03, 4'h0, 1'b0);
        repeat (8) step(1'b0, 8'h00, 8'h00, 8'h00);
        check("idle_after_abort", 8'h03, 4'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
